// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: fetch stage drives req/addr, memory answers with a valid strobe.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) ();
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, fills the IF/ID register
// through a one-entry skid buffer and injects NOP bubbles on redirect.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam logic [INSTR_W-1:0] NOP = {4'b1111, {(INSTR_W-4){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD,
    S_FULL
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic [ADDR_W-1:0]  pending_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
      if_valid       <= 1'b0;
      if_instr       <= NOP;
      if_pc          <= '0;
      skid_instr     <= NOP;
      skid_pc        <= '0;
      pending_pc     <= '0;
    end else if (redirect) begin
      // Flush wins over stall and over any response arriving this cycle.
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= '0;
      if (imem.imem_req && !imem.imem_valid) begin
        pending_pc <= redirect_pc;
        state      <= S_DISCARD;
      end else begin
        imem.imem_addr <= redirect_pc;
        imem.imem_req  <= 1'b1;
        state          <= S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: begin
          imem.imem_req  <= 1'b1;
          imem.imem_addr <= RESET_PC;
          state          <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.imem_valid) begin
            imem.imem_addr <= imem.imem_addr + ADDR_W'(1);
            if (!stall) begin
              if_valid <= 1'b1;
              if_instr <= imem.imem_rdata;
              if_pc    <= imem.imem_addr;
            end else begin
              // Decode is blocked: park the response and stop requesting.
              skid_instr    <= imem.imem_rdata;
              skid_pc       <= imem.imem_addr;
              imem.imem_req <= 1'b0;
              state         <= S_FULL;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
            if_pc    <= '0;
          end
        end
        S_DISCARD: begin
          if (imem.imem_valid) begin
            imem.imem_addr <= pending_pc;
            state          <= S_FETCH;
          end
        end
        S_FULL: begin
          if (!stall) begin
            if_valid      <= 1'b1;
            if_instr      <= skid_instr;
            if_pc         <= skid_pc;
            imem.imem_req <= 1'b1;
            state         <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table, hand sequences, and a streaming scoreboard.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       if_valid;
  logic [15:0] if_instr;
  logic [7:0] if_pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: manual strobe, or automatic response after lat wait cycles.
  logic auto_mode;
  logic man_valid;
  int   lat;
  int   wait_cnt;

  assign bus.imem_valid = bus.imem_req && (auto_mode ? (wait_cnt >= lat) : man_valid);
  assign bus.imem_rdata = {bus.imem_addr[3:0], 12'h000};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wait_cnt <= 0;
    else if (!bus.imem_req || bus.imem_valid) wait_cnt <= 0;
    else                                     wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected {pc, instr} pushed per accepted response, popped when decode consumes.
  logic        sb_en;
  logic [7:0]  exp_next;
  logic [23:0] sb_q[$];
  int          n_pop;

  always @(posedge clk) begin
    if (sb_en && rst_n) begin
      if (if_valid && !stall) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_instr", 32'({if_pc, if_instr}), 32'hFFFF_FFFF);
        end else begin
          chk("sb_instr", 32'({if_pc, if_instr}), 32'(sb_q.pop_front()));
          n_pop++;
        end
      end
      if (bus.imem_req && bus.imem_valid) begin
        chk("sb_addr", 32'(bus.imem_addr), 32'(exp_next));
        sb_q.push_back({exp_next, exp_next[3:0], 12'h000});
        exp_next = exp_next + 8'd1;
      end
    end
  end

  typedef struct {
    logic        v;
    logic        s;
    logic        r;
    logic [7:0]  rpc;
    logic        ereq;
    logic [7:0]  eaddr;
    logic        ev;
    logic [15:0] einstr;
    logic [7:0]  epc;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  initial begin
    // valid, stall, redirect, redirect_pc | req, addr, if_valid, if_instr, if_pc (after the edge)
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'hF000, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 16'h0000, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 16'h1000, 8'h01};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 16'h2000, 8'h02};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 16'h3000, 8'h03};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 16'h4000, 8'h04};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 16'h4000, 8'h04};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 16'h4000, 8'h04};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 16'h4000, 8'h04};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 16'h5000, 8'h05};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 16'h6000, 8'h06};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 8'h07, 1'b0, 16'hF000, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 16'hF000, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 16'hF000, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 16'h0000, 8'h40};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 8'hFE, 1'b1, 8'hFE, 1'b0, 16'hF000, 8'h00};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 16'hE000, 8'hFE};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 16'hF000, 8'hFF};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 16'h0000, 8'h00};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 8'h01, 1'b0, 16'hF000, 8'h00};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 8'h01, 1'b0, 16'hF000, 8'h00};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 16'hF000, 8'h00};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 1'b1, 16'h0000, 8'h20};

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    auto_mode   = 1'b0;
    man_valid   = 1'b0;
    lat         = 0;
    sb_en       = 1'b0;
    exp_next    = 8'h00;
    n_pop       = 0;

    #12;
    chk("rst_req",    32'(bus.imem_req),  32'd0);
    chk("rst_addr",   32'(bus.imem_addr), 32'h00);
    chk("rst_valid",  32'(if_valid),      32'd0);
    chk("rst_instr",  32'(if_instr),      32'hF000);
    chk("rst_pc",     32'(if_pc),         32'h00);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      man_valid   = vecs[i].v;
      stall       = vecs[i].s;
      redirect    = vecs[i].r;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_req", i),   32'(bus.imem_req),  32'(vecs[i].ereq));
      chk($sformatf("vec%0d_addr", i),  32'(bus.imem_addr), 32'(vecs[i].eaddr));
      chk($sformatf("vec%0d_valid", i), 32'(if_valid),      32'(vecs[i].ev));
      chk($sformatf("vec%0d_instr", i), 32'(if_instr),      32'(vecs[i].einstr));
      chk($sformatf("vec%0d_pc", i),    32'(if_pc),         32'(vecs[i].epc));
    end

    // Reset asserted mid-cycle while a request is outstanding.
    @(negedge clk);
    man_valid = 1'b0;
    stall     = 1'b0;
    redirect  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",   32'(bus.imem_req),  32'd0);
    chk("async_rst_valid", 32'(if_valid),      32'd0);
    chk("async_rst_addr",  32'(bus.imem_addr), 32'h00);
    chk("async_rst_instr", 32'(if_instr),      32'hF000);

    // Two-cycle memory: a bubble between every pair of instructions.
    auto_mode = 1'b1;
    lat       = 1;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (if_valid) seen = 1'b1;
      end
      chk("lat2_first_valid_seen", 32'(seen), 32'd1);
      chk("lat2_first_pc", 32'(if_pc), 32'h00);
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("lat2_valid_c%0d", k), 32'(if_valid), 32'((k % 2) == 0));
        if ((k % 2) == 1) chk($sformatf("lat2_bubble_c%0d", k), 32'(if_instr), 32'hF000);
        else              chk($sformatf("lat2_pc_c%0d", k), 32'(if_pc), 32'(k / 2));
      end
    end

    // Streaming with random stalls under several memory latencies.
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    exp_next = 8'h00;
    sb_en    = 1'b1;
    lat      = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      lat = (p == 0) ? 0 : (p == 1) ? 2 : 1;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        stall = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    sb_en = 1'b0;
    stall = 1'b0;
    chk("sb_leftover_le2", 32'(sb_q.size() <= 2), 32'd1);
    chk("sb_progress", 32'(n_pop > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
